e203_nice_csr_req: RTL and testbench



---
 rtl/e203_nice_csr_pkg.sv | 27 ++
 rtl/e203_nice_csr_tmo.sv | 39 +++
 rtl/e203_nice_csr_req.sv | 138 +++++++++++++
 tb/tb_e203_nice_csr_req.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/e203_nice_csr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : e203_nice_csr_pkg                                          |
// | Brief   : Shared types, default CSR window and address helper for    |
// |           the NICE CSR request initiator.                            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package e203_nice_csr_pkg;

  // Transaction phases of the initiator.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } nice_csr_state_e;

  // Default custom CSR window: 0xBC0..0xBFF.
  localparam logic [11:0] NICE_CSR_BASE = 12'hBC0;
  localparam logic [11:0] NICE_CSR_MASK = 12'hFC0;

  // The NICE bus carries a 32-bit address; CSR numbers are zero-extended.
  function automatic logic [31:0] nice_addr_ext(input logic [11:0] addr);
    return {20'b0, addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/e203_nice_csr_tmo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : e203_nice_csr_tmo                                          |
// | Brief   : Request timeout counter. Cleared at request accept,        |
// |           counts cycles the responder leaves the request waiting,    |
// |           flags the last permitted cycle.                            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module e203_nice_csr_tmo #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int              CW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   c_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // Count waiting cycles; saturate on the last one so it can never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expired means the current cycle is the final one the request may wait.
  assign expired = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/e203_nice_csr_req.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : e203_nice_csr_req                                          |
// | Brief   : NICE CSR handshake initiator. Forwards accesses inside the |
// |           custom CSR window to the extended-CSR responder, returns   |
// |           read data or an error (out of window / timeout).           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module e203_nice_csr_req
  import e203_nice_csr_pkg::*;
#(
  parameter logic [11:0] ADDR_BASE   = NICE_CSR_BASE,
  parameter logic [11:0] ADDR_MASK   = NICE_CSR_MASK,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_i_valid,
  output logic        csr_i_ready,
  input  logic [11:0] csr_i_addr,
  input  logic        csr_i_wr,
  input  logic [31:0] csr_i_wdata,
  output logic        csr_o_valid,
  input  logic        csr_o_ready,
  output logic [31:0] csr_o_rdata,
  output logic        csr_o_err,
  output logic        nice_csr_valid,
  input  logic        nice_csr_ready,
  output logic [31:0] nice_csr_addr,
  output logic        nice_csr_wr,
  output logic [31:0] nice_csr_wdata,
  input  logic [31:0] nice_csr_rdata
);

  nice_csr_state_e r_state;
  nice_csr_state_e w_state_nxt;

  logic [11:0] r_addr;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_idle;
  logic w_req;
  logic w_rsp;
  logic w_accept;
  logic w_hit;
  logic w_expired;

  assign w_idle   = (r_state == IDLE);
  assign w_req    = (r_state == REQ);
  assign w_rsp    = (r_state == RSP);
  assign w_accept = csr_i_valid & csr_i_ready;
  assign w_hit    = ((csr_i_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

  e203_nice_csr_tmo #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_idle & w_accept),
    .inc     (w_req & ~nice_csr_ready),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a ready in the final permitted cycle beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_hit ? REQ : RSP;
        end
      end
      REQ: begin
        if (nice_csr_ready || w_expired) begin
          w_state_nxt = RSP;
        end
      end
      RSP: begin
        if (csr_o_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latches and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_idle && w_accept) begin
        r_addr  <= csr_i_addr;
        r_wr    <= csr_i_wr;
        r_wdata <= csr_i_wdata;
        r_rdata <= '0;
        r_err   <= ~w_hit;
      end
      if (w_req) begin
        if (nice_csr_ready) begin
          r_rdata <= r_wr ? 32'b0 : nice_csr_rdata;
          r_err   <= 1'b0;
        end else if (w_expired) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  // Outputs decode from state and registers only; rst_n gates the upstream ready.
  assign csr_i_ready    = w_idle & rst_n;
  assign nice_csr_valid = w_req;
  assign nice_csr_addr  = w_req ? nice_addr_ext(r_addr) : 32'b0;
  assign nice_csr_wr    = w_req & r_wr;
  assign nice_csr_wdata = w_req ? r_wdata : 32'b0;
  assign csr_o_valid    = w_rsp;
  assign csr_o_rdata    = w_rsp ? r_rdata : 32'b0;
  assign csr_o_err      = w_rsp & r_err;

endmodule
`default_nettype wire

// File: tb/tb_e203_nice_csr_req.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_e203_nice_csr_req                                       |
// | Brief   : Directed, table-driven bench for e203_nice_csr_req.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_e203_nice_csr_req;

  logic        clk;
  logic        rst_n;
  logic        csr_i_valid;
  logic        csr_i_ready;
  logic [11:0] csr_i_addr;
  logic        csr_i_wr;
  logic [31:0] csr_i_wdata;
  logic        csr_o_valid;
  logic        csr_o_ready;
  logic [31:0] csr_o_rdata;
  logic        csr_o_err;
  logic        nice_csr_valid;
  logic        nice_csr_ready;
  logic [31:0] nice_csr_addr;
  logic        nice_csr_wr;
  logic [31:0] nice_csr_wdata;
  logic [31:0] nice_csr_rdata;

  int total = 0;
  int bad   = 0;

  e203_nice_csr_req #(
    .ADDR_BASE   (12'hBC0),
    .ADDR_MASK   (12'hFC0),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr_i_valid    (csr_i_valid),
    .csr_i_ready    (csr_i_ready),
    .csr_i_addr     (csr_i_addr),
    .csr_i_wr       (csr_i_wr),
    .csr_i_wdata    (csr_i_wdata),
    .csr_o_valid    (csr_o_valid),
    .csr_o_ready    (csr_o_ready),
    .csr_o_rdata    (csr_o_rdata),
    .csr_o_err      (csr_o_err),
    .nice_csr_valid (nice_csr_valid),
    .nice_csr_ready (nice_csr_ready),
    .nice_csr_addr  (nice_csr_addr),
    .nice_csr_wr    (nice_csr_wr),
    .nice_csr_wdata (nice_csr_wdata),
    .nice_csr_rdata (nice_csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] resp_rdata;
    int          rdy_after;   // responder ready on valid cycle rdy_after+1; large = never
    int          exp_vcnt;    // cycles nice_csr_valid is high
    int          exp_cyc;     // cycle of csr_o_valid, accept = cycle 0
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and follow it to its response, all driving/sampling at negedge.
  task automatic run_txn(input vec_t v, input int idx);
    int vcnt;
    int rcyc;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, " in_ready"}, {31'b0, csr_i_ready}, 32'd1);
    csr_i_valid    = 1'b1;
    csr_i_addr     = v.addr;
    csr_i_wr       = v.wr;
    csr_i_wdata    = v.wdata;
    nice_csr_ready = 1'b0;
    nice_csr_rdata = v.resp_rdata;
    @(negedge clk);
    csr_i_valid = 1'b0;
    vcnt = 0;
    rcyc = -1;
    for (int n = 1; n <= 40; n++) begin
      if (csr_o_valid) begin
        rcyc = n;
        break;
      end
      if (nice_csr_valid) begin
        if (vcnt == 0) begin
          chk({tag, " nice_addr"}, nice_csr_addr, {20'b0, v.addr});
          chk({tag, " nice_wr"}, {31'b0, nice_csr_wr}, {31'b0, v.wr});
          chk({tag, " nice_wdata"}, nice_csr_wdata, v.wdata);
        end
        nice_csr_ready = (vcnt == v.rdy_after);
        vcnt++;
      end else begin
        nice_csr_ready = 1'b0;
      end
      @(negedge clk);
    end
    nice_csr_ready = 1'b0;
    if (rcyc < 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no csr_o_valid within 40 cycles", tag);
    end else begin
      chk({tag, " vcnt"}, vcnt, v.exp_vcnt);
      chk({tag, " rsp_cycle"}, rcyc, v.exp_cyc);
      chk({tag, " rdata"}, csr_o_rdata, v.exp_rdata);
      chk({tag, " err"}, {31'b0, csr_o_err}, {31'b0, v.exp_err});
      chk({tag, " nice_valid_in_rsp"}, {31'b0, nice_csr_valid}, 32'd0);
      @(negedge clk);
      chk({tag, " idle_o_valid"}, {31'b0, csr_o_valid}, 32'd0);
    end
  endtask

  initial begin
    // addr, wr, wdata, resp_rdata, rdy_after, vcnt, cyc, rdata, err
    vecs[0] = '{12'hBC5, 1'b0, 32'h0,         32'hDEADBEEF, 0,   1,  2,  32'hDEADBEEF, 1'b0};
    vecs[1] = '{12'hBFF, 1'b1, 32'h12345678,  32'hAAAA5555, 0,   1,  2,  32'h0,        1'b0};
    vecs[2] = '{12'h300, 1'b0, 32'h0,         32'h11111111, 0,   0,  1,  32'h0,        1'b1};
    vecs[3] = '{12'hBC0, 1'b0, 32'h0,         32'h22222222, 999, 16, 17, 32'h0,        1'b1};
    vecs[4] = '{12'hBC1, 1'b0, 32'h0,         32'hCAFEF00D, 15,  16, 17, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{12'hBC2, 1'b0, 32'h0,         32'h01020304, 3,   4,  5,  32'h01020304, 1'b0};
    vecs[6] = '{12'hBD0, 1'b1, 32'hA5A5F00F,  32'h33333333, 14,  15, 16, 32'h0,        1'b0};
    vecs[7] = '{12'hC00, 1'b0, 32'h0,         32'h44444444, 0,   0,  1,  32'h0,        1'b1};
    vecs[8] = '{12'hB80, 1'b1, 32'h55555555,  32'h44444444, 0,   0,  1,  32'h0,        1'b1};

    rst_n          = 1'b0;
    csr_i_valid    = 1'b0;
    csr_i_addr     = '0;
    csr_i_wr       = 1'b0;
    csr_i_wdata    = '0;
    csr_o_ready    = 1'b1;
    nice_csr_ready = 1'b0;
    nice_csr_rdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst in_ready", {31'b0, csr_i_ready}, 32'd0);
    chk("rst o_valid", {31'b0, csr_o_valid}, 32'd0);
    chk("rst nice_valid", {31'b0, nice_csr_valid}, 32'd0);
    chk("rst nice_addr", nice_csr_addr, 32'd0);
    chk("rst o_rdata", csr_o_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready", {31'b0, csr_i_ready}, 32'd1);

    foreach (vecs[i]) run_txn(vecs[i], i);

    // Response backpressure: hold csr_o_ready low 5 cycles with a new request pending.
    begin
      int n;
      @(negedge clk);
      csr_o_ready    = 1'b0;
      csr_i_valid    = 1'b1;
      csr_i_addr     = 12'hBC5;
      csr_i_wr       = 1'b0;
      nice_csr_rdata = 32'h0BADF00D;
      nice_csr_ready = 1'b1;
      @(negedge clk);
      csr_i_valid = 1'b0;
      chk("bp nice_valid", {31'b0, nice_csr_valid}, 32'd1);
      @(negedge clk);
      nice_csr_ready = 1'b0;
      csr_i_valid    = 1'b1;
      csr_i_addr     = 12'h300;
      for (n = 0; n < 5; n++) begin
        chk($sformatf("bp%0d o_valid", n), {31'b0, csr_o_valid}, 32'd1);
        chk($sformatf("bp%0d rdata", n), csr_o_rdata, 32'h0BADF00D);
        chk($sformatf("bp%0d err", n), {31'b0, csr_o_err}, 32'd0);
        chk($sformatf("bp%0d in_ready", n), {31'b0, csr_i_ready}, 32'd0);
        if (n == 4) csr_o_ready = 1'b1;
        @(negedge clk);
      end
      // First IDLE cycle: the held request was not taken during RSP.
      chk("bp idle in_ready", {31'b0, csr_i_ready}, 32'd1);
      chk("bp idle o_valid", {31'b0, csr_o_valid}, 32'd0);
      @(negedge clk);
      csr_i_valid = 1'b0;
      chk("bp miss o_valid", {31'b0, csr_o_valid}, 32'd1);
      chk("bp miss err", {31'b0, csr_o_err}, 32'd1);
      @(negedge clk);
    end

    // Reset pulse mid-REQ abandons the access with no response.
    begin
      @(negedge clk);
      csr_i_valid    = 1'b1;
      csr_i_addr     = 12'hBC7;
      csr_i_wr       = 1'b0;
      nice_csr_ready = 1'b0;
      @(negedge clk);
      csr_i_valid = 1'b0;
      @(negedge clk);
      chk("rq nice_valid", {31'b0, nice_csr_valid}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rq rst nice_valid", {31'b0, nice_csr_valid}, 32'd0);
      chk("rq rst o_valid", {31'b0, csr_o_valid}, 32'd0);
      chk("rq rst in_ready", {31'b0, csr_i_ready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rq idle in_ready", {31'b0, csr_i_ready}, 32'd1);
      for (int k = 0; k < 20; k++) begin
        if (csr_o_valid || nice_csr_valid) begin
          chk($sformatf("rq quiet%0d", k), {30'b0, csr_o_valid, nice_csr_valid}, 32'd0);
        end
        @(negedge clk);
      end
      chk("rq quiet end", {30'b0, csr_o_valid, nice_csr_valid}, 32'd0);
    end

    // One more normal access after the reset.
    run_txn(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
